// File: rtl/segcap_pkg.sv
// Shared constants for the 7-segment readback path: digit patterns (gfedcba),
// digit-slot indices and small helpers used by segment_capture.
package segcap_pkg;

    localparam int VAL_W      = 6;
    localparam int NUM_DIGITS = 4;
    localparam int SEG_W      = 7;
    localparam int BCD_W      = 4;

    typedef logic [BCD_W-1:0] bcd_t;
    typedef logic [SEG_W-1:0] seg_t;

    // Segment patterns, bit0 = a ... bit6 = g, active-high.
    localparam seg_t SEG_0 = 7'h3F;
    localparam seg_t SEG_1 = 7'h06;
    localparam seg_t SEG_2 = 7'h5B;
    localparam seg_t SEG_3 = 7'h4F;
    localparam seg_t SEG_4 = 7'h66;
    localparam seg_t SEG_5 = 7'h6D;
    localparam seg_t SEG_6 = 7'h7D;
    localparam seg_t SEG_7 = 7'h07;
    localparam seg_t SEG_8 = 7'h7F;
    localparam seg_t SEG_9 = 7'h6F;

    localparam int LO_ONES = 0;
    localparam int LO_TENS = 1;
    localparam int HI_ONES = 2;
    localparam int HI_TENS = 3;

    function automatic logic is_onehot4(input logic [NUM_DIGITS-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    function automatic logic [1:0] slot_index(input logic [NUM_DIGITS-1:0] onehot);
        logic [1:0] idx;
        idx = 2'd0;
        case (onehot)
            4'b0001: idx = 2'(LO_ONES);
            4'b0010: idx = 2'(LO_TENS);
            4'b0100: idx = 2'(HI_ONES);
            4'b1000: idx = 2'(HI_TENS);
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Two BCD digits to a binary value; 7 bits holds the worst case of 99.
    function automatic logic [6:0] combine_digits(input bcd_t tens, input bcd_t ones);
        return ({3'b000, tens} * 7'd10) + {3'b000, ones};
    endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational decoder from an active-high 7-segment pattern to a BCD digit;
// anything that is not 0-9 flags invalid and decodes as 0.
module seg7_to_bcd
    import segcap_pkg::*;
(
    input  logic [SEG_W-1:0] pattern,
    output logic [BCD_W-1:0] digit,
    output logic             invalid
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        digit   = '0;
        invalid = 1'b0;
        case (pattern)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/segment_capture.sv
// Snoops a scanned 4-digit 7-segment display and rebuilds the two 6-bit values.
// Build option: define SEGCAP_ACTIVE_LOW_EN for common-anode (inverted) segments.
module segment_capture
    import segcap_pkg::*;
#(
    parameter int SETTLE = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_DIGITS-1:0]   bytee,
    input  logic [SEG_W-1:0]        segment,
    input  logic                    clr_err,
    output logic [2*VAL_W-1:0]      data_out,
    output logic                    frame_valid,
    output logic                    pattern_err,
    output logic                    range_err
);

    localparam int               CNT_W      = $clog2(SETTLE + 1);
    localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE);
    localparam logic [6:0]       VAL_MAX    = 7'((1 << VAL_W) - 1);

    logic [NUM_DIGITS-1:0]       en_q;
    logic [CNT_W-1:0]            cnt;
    logic [CNT_W-1:0]            cnt_next;
    logic [NUM_DIGITS-1:0]       seen;
    logic [NUM_DIGITS-1:0]       seen_next;
    bcd_t [NUM_DIGITS-1:0]       slot;

    logic [SEG_W-1:0]            seg_in;
    logic [BCD_W-1:0]            dec_digit;
    logic                        dec_invalid;
    logic                        same_en;
    logic                        capture;
    logic                        publish;
    logic [1:0]                  cap_idx;
    logic [6:0]                  low_val;
    logic [6:0]                  high_val;
    logic                        out_of_range;

`ifdef SEGCAP_ACTIVE_LOW_EN
    assign seg_in = ~segment;
`else
    assign seg_in = segment;
`endif

    seg7_to_bcd u_decode (
        .pattern (seg_in),
        .digit   (dec_digit),
        .invalid (dec_invalid)
    );

    always_comb begin
        same_en  = (bytee == en_q);
        cnt_next = CNT_W'(1);
        if (same_en) begin
            cnt_next = (cnt == SETTLE_CNT) ? cnt : cnt + 1'b1;
        end

        // Fires only on the edge where the dwell count first lands on SETTLE.
        capture = is_onehot4(bytee) && same_en
                  && (cnt_next == SETTLE_CNT) && (cnt != SETTLE_CNT);
        cap_idx = slot_index(bytee);

        // A completed frame is published one edge after its last capture.
        publish = (seen == '1);

        seen_next = publish ? '0 : seen;
        if (capture) begin
            seen_next = seen_next | bytee;
        end

        low_val      = combine_digits(slot[LO_TENS], slot[LO_ONES]);
        high_val     = combine_digits(slot[HI_TENS], slot[HI_ONES]);
        out_of_range = (low_val > VAL_MAX) || (high_val > VAL_MAX);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            en_q        <= '0;
            cnt         <= '0;
            seen        <= '0;
            // NOTE: the digit slots are a four-entry register file, so they are
            // cleared with the rest of the state; a partial frame never survives reset.
            slot        <= '0;
            data_out    <= '0;
            frame_valid <= 1'b0;
            pattern_err <= 1'b0;
            range_err   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register sees
            // the pre-edge values of the others regardless of statement order.
            en_q        <= bytee;
            cnt         <= cnt_next;
            seen        <= seen_next;
            frame_valid <= publish;

            if (capture) begin
                slot[cap_idx] <= dec_digit;
            end

            if (publish) begin
                data_out <= {high_val[VAL_W-1:0], low_val[VAL_W-1:0]};
            end

            if (clr_err) begin
                pattern_err <= 1'b0;
                range_err   <= 1'b0;
            end else begin
                if (capture && dec_invalid) begin
                    pattern_err <= 1'b1;
                end
                if (publish && out_of_range) begin
                    range_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_segment_capture.sv
// Self-checking bench for segment_capture: directed display scans plus random
// scans, compared every cycle against a frame-level reference model.
module tb_segment_capture;

    localparam int SETTLE = 4;

    logic        clock;
    logic        reset;
    logic [3:0]  bytee;
    logic [6:0]  segment;
    logic        clr_err;
    logic [11:0] data_out;
    logic        frame_valid;
    logic        pattern_err;
    logic        range_err;

    segment_capture #(.SETTLE(SETTLE)) dut (
        .clock       (clock),
        .reset       (reset),
        .bytee       (bytee),
        .segment     (segment),
        .clr_err     (clr_err),
        .data_out    (data_out),
        .frame_valid (frame_valid),
        .pattern_err (pattern_err),
        .range_err   (range_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp   = 0;
    int n_fail  = 0;
    int n_frames = 0;

    logic [6:0] pat_tab [10];

    // Reference model state: display digits, which were seen, run length of the
    // current enable value, and the outputs expected after the next edge.
    logic [3:0]  m_prev;
    int          m_run;
    int          m_dig [4];
    logic [3:0]  m_seen;
    bit          m_pend;
    logic [11:0] e_data;
    logic        e_valid;
    logic        e_perr;
    logic        e_rerr;

    function automatic int decode_ref(input logic [6:0] p);
        for (int i = 0; i < 10; i++) begin
            if (p == pat_tab[i]) return i;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic [3:0] b, input logic [6:0] lseg,
                              input logic c, input logic rst_n);
        int lo;
        int hi;
        int d;
        if (!rst_n) begin
            m_prev  = '0;
            m_run   = 0;
            m_seen  = '0;
            m_pend  = 0;
            e_data  = '0;
            e_valid = 1'b0;
            e_perr  = 1'b0;
            e_rerr  = 1'b0;
            for (int i = 0; i < 4; i++) m_dig[i] = 0;
        end else begin
            m_run  = (b == m_prev) ? m_run + 1 : 1;
            m_prev = b;
            e_valid = m_pend;
            if (m_pend) begin
                lo = 10 * m_dig[1] + m_dig[0];
                hi = 10 * m_dig[3] + m_dig[2];
                e_data = 12'((hi % 64) * 64 + (lo % 64));
                if (lo > 63 || hi > 63) e_rerr = 1'b1;
                m_seen = '0;
            end
            if ($countones(b) == 1 && m_run == SETTLE) begin
                d = decode_ref(lseg);
                if (d < 0) begin
                    e_perr = 1'b1;
                    d = 0;
                end
                for (int i = 0; i < 4; i++) begin
                    if (b[i]) m_dig[i] = d;
                end
                m_seen = m_seen | b;
            end
            if (c) begin
                e_perr = 1'b0;
                e_rerr = 1'b0;
            end
            m_pend = (m_seen == 4'hF);
        end
    endtask

    task automatic tick(input logic [3:0] b, input logic [6:0] lseg, input logic c);
        bytee = b;
`ifdef SEGCAP_ACTIVE_LOW_EN
        segment = ~lseg;
`else
        segment = lseg;
`endif
        clr_err = c;
        model_edge(b, lseg, c, reset);
        @(posedge clock);
        #1;
        check("frame_valid", {11'b0, frame_valid}, {11'b0, e_valid});
        check("data_out", data_out, e_data);
        check("pattern_err", {11'b0, pattern_err}, {11'b0, e_perr});
        check("range_err", {11'b0, range_err}, {11'b0, e_rerr});
        if (frame_valid === 1'b1) n_frames++;
    endtask

    task automatic hold(input logic [3:0] b, input logic [6:0] lseg, input int n);
        for (int i = 0; i < n; i++) tick(b, lseg, 1'b0);
    endtask

    // Full scan in slot order: low ones, low tens, high ones, high tens.
    task automatic scan(input logic [6:0] p0, input logic [6:0] p1,
                        input logic [6:0] p2, input logic [6:0] p3);
        hold(4'b0001, p0, 6);
        hold(4'b0010, p1, 6);
        hold(4'b0100, p2, 6);
        hold(4'b1000, p3, 6);
        hold(4'b0000, 7'h00, 2);
    endtask

    int sec_start;

    initial begin
        pat_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        reset   = 1'b0;
        bytee   = '0;
        segment = '0;
        clr_err = 1'b0;

        // Reset state
        hold(4'b0000, 7'h00, 2);
        check("reset_data", data_out, 12'h000);
        check("reset_valid", {11'b0, frame_valid}, 12'h000);
        check("reset_flags", {10'b0, pattern_err, range_err}, 12'h000);
        reset = 1'b1;
        hold(4'b0000, 7'h00, 2);

        // Scan 12:34
        sec_start = n_frames;
        scan(pat_tab[4], pat_tab[3], pat_tab[2], pat_tab[1]);
        check("scan_1234_data", data_out, 12'h322);
        check("scan_1234_frames", 12'(n_frames - sec_start), 12'd1);
        check("scan_1234_flags", {10'b0, pattern_err, range_err}, 12'h000);

        // Dwell glitch on the last slot: first short dwell must not capture
        sec_start = n_frames;
        hold(4'b0010, pat_tab[0], 6);
        hold(4'b0100, pat_tab[0], 6);
        hold(4'b1000, pat_tab[0], 6);
        hold(4'b0001, pat_tab[1], 3);
        tick(4'b0000, pat_tab[8], 1'b0);
        hold(4'b0001, pat_tab[2], 3);
        tick(4'b0001, pat_tab[7], 1'b0);
        hold(4'b0001, pat_tab[3], 2);
        hold(4'b0000, 7'h00, 2);
        check("glitch_data", data_out, 12'd7);
        check("glitch_frames", 12'(n_frames - sec_start), 12'd1);

        // Invalid pattern on low tens
        scan(pat_tab[5], 7'h00, pat_tab[2], pat_tab[4]);
        check("invalid_perr", {11'b0, pattern_err}, 12'd1);
        check("invalid_low", {6'b0, data_out[5:0]}, 12'd5);
        scan(pat_tab[4], pat_tab[3], pat_tab[2], pat_tab[1]);
        check("perr_sticky", {11'b0, pattern_err}, 12'd1);
        check("perr_sticky_data", data_out, 12'h322);
        tick(4'b0000, 7'h00, 1'b1);
        check("perr_cleared", {11'b0, pattern_err}, 12'd0);

        // Out of range: high = 99
        scan(pat_tab[1], pat_tab[0], pat_tab[9], pat_tab[9]);
        check("range_err_set", {11'b0, range_err}, 12'd1);
        check("range_high", {6'b0, data_out[11:6]}, 12'd35);
        check("range_data", data_out, 12'(35 * 64 + 1));
        tick(4'b0000, 7'h00, 1'b1);
        check("range_cleared", {11'b0, range_err}, 12'd0);

        // Multi-hot enable in the middle of a frame
        sec_start = n_frames;
        hold(4'b0001, pat_tab[8], 6);
        hold(4'b0010, pat_tab[0], 6);
        hold(4'b0011, pat_tab[3], 10);
        check("multihot_no_frame", 12'(n_frames - sec_start), 12'd0);
        hold(4'b0100, pat_tab[1], 6);
        hold(4'b1000, pat_tab[2], 6);
        hold(4'b0000, 7'h00, 2);
        check("multihot_frames", 12'(n_frames - sec_start), 12'd1);
        check("multihot_data", data_out, 12'h548);
        check("multihot_flags", {10'b0, pattern_err, range_err}, 12'h000);

        // Reset after two of four captures
        sec_start = n_frames;
        hold(4'b0001, pat_tab[3], 6);
        hold(4'b0010, pat_tab[4], 6);
        reset = 1'b0;
        hold(4'b0000, 7'h00, 2);
        check("midreset_data", data_out, 12'h000);
        reset = 1'b1;
        hold(4'b0100, pat_tab[2], 6);
        hold(4'b1000, pat_tab[1], 6);
        hold(4'b0000, 7'h00, 2);
        check("midreset_no_frame", 12'(n_frames - sec_start), 12'd0);
        scan(pat_tab[4], pat_tab[3], pat_tab[2], pat_tab[1]);
        check("midreset_rescan_frames", 12'(n_frames - sec_start), 12'd1);
        check("midreset_rescan_data", data_out, 12'h322);

        // Random scans: shuffled slot order, random dwells, glitches, bad patterns
        for (int it = 0; it < 40; it++) begin
            logic [6:0] p [4];
            int order [4];
            int j;
            int t;
            int n;
            logic [6:0] lseg;
            for (int k = 0; k < 4; k++) begin
                p[k] = ($urandom_range(0, 7) == 0) ? 7'($urandom())
                                                   : pat_tab[$urandom_range(0, 9)];
                order[k] = k;
            end
            for (int k = 3; k > 0; k--) begin
                j = $urandom_range(0, k);
                t = order[k];
                order[k] = order[j];
                order[j] = t;
            end
            if ($urandom_range(0, 19) == 0) begin
                reset = 1'b0;
                tick(4'b0000, 7'h00, 1'b0);
                reset = 1'b1;
            end
            for (int k = 0; k < 4; k++) begin
                n = $urandom_range(1, 7);
                for (int c = 0; c < n; c++) begin
                    lseg = ($urandom_range(0, 5) == 0) ? pat_tab[$urandom_range(0, 9)] : p[k];
                    tick(4'(1 << order[k]), lseg, 1'($urandom_range(0, 24) == 0));
                end
                if ($urandom_range(0, 3) == 0) begin
                    tick(4'($urandom()), 7'($urandom()), 1'b0);
                end
            end
        end
        hold(4'b0000, 7'h00, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
